// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS control path: FSM states, opcode/funct values,
// ALU codes, mux select codes and the registered control-word layout.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTE, ALUWB, BRANCH, IMMEXEC, IMMWB, JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Moore part of the control word; pcjump is the unconditional PC load of JUMP.
  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       pcjump;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       ext_zero;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_J: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ctrl_t fetch_ctrl();
    ctrl_t c;
    c            = '0;
    c.mem_req    = 1'b1;
    c.alusrcb    = SRCB_FOUR;
    c.alucontrol = ALU_ADD;
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational funct -> alucontrol map for R-type instructions; unknown
// funct values fall back to add rather than trapping.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_SLT:  alucontrol = ALU_SLT;
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over the shared
// datapath, stalling on mem_ready in the three memory-access states.
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       ext_zero,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal_op
);

  state_t     state, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [2:0] funct_alu;

  alu_decoder u_alu_decoder (
    .funct      (funct),
    .alucontrol (funct_alu)
  );

  always_comb begin
    state_d = state;
    case (state)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:               state_d = MEMADR;
          OP_RTYPE:                   state_d = EXECUTE;
          OP_BEQ:                     state_d = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:   state_d = IMMEXEC;
          OP_J:                       state_d = JUMP;
          default:                    state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      EXECUTE:  state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      IMMEXEC:  state_d = IMMWB;
      IMMWB:    state_d = FETCH;
      JUMP:     state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  // Control word for the state being entered, so outputs come straight from flops.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      FETCH:    ctrl_d = fetch_ctrl();
      DECODE: begin
        ctrl_d.alusrcb    = SRCB_IMMSH;
        ctrl_d.alucontrol = ALU_ADD;
      end
      MEMADR: begin
        ctrl_d.alusrca    = 1'b1;
        ctrl_d.alusrcb    = SRCB_IMM;
        ctrl_d.alucontrol = ALU_ADD;
      end
      MEMREAD: begin
        ctrl_d.mem_req = 1'b1;
        ctrl_d.iord    = 1'b1;
      end
      MEMWB: begin
        ctrl_d.regwrite = 1'b1;
        ctrl_d.memtoreg = 1'b1;
      end
      MEMWRITE: begin
        ctrl_d.mem_req  = 1'b1;
        ctrl_d.iord     = 1'b1;
        ctrl_d.memwrite = 1'b1;
      end
      EXECUTE: begin
        ctrl_d.alusrca    = 1'b1;
        ctrl_d.alusrcb    = SRCB_RT;
        ctrl_d.alucontrol = funct_alu;
      end
      ALUWB: begin
        ctrl_d.regwrite = 1'b1;
        ctrl_d.regdst   = 1'b1;
      end
      BRANCH: begin
        ctrl_d.alusrca    = 1'b1;
        ctrl_d.alusrcb    = SRCB_RT;
        ctrl_d.alucontrol = ALU_SUB;
        ctrl_d.pcsrc      = PCSRC_ALUOUT;
      end
      IMMEXEC: begin
        ctrl_d.alusrca    = 1'b1;
        ctrl_d.alusrcb    = SRCB_IMM;
        ctrl_d.ext_zero   = (opcode != OP_ADDI);
        ctrl_d.alucontrol = (opcode == OP_ANDI) ? ALU_AND :
                            (opcode == OP_ORI)  ? ALU_OR  : ALU_ADD;
      end
      IMMWB: begin
        ctrl_d.regwrite   = 1'b1;
        ctrl_d.ext_zero   = ctrl_q.ext_zero;
        ctrl_d.alucontrol = ctrl_q.alucontrol;
      end
      JUMP: begin
        ctrl_d.pcjump = 1'b1;
        ctrl_d.pcsrc  = PCSRC_JUMP;
      end
      default:  ctrl_d = fetch_ctrl();
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FETCH;
      ctrl_q <= fetch_ctrl();
    end else begin
      state  <= state_d;
      ctrl_q <= ctrl_d;
    end
  end

  // Strobes are gated by rst_n so asserting reset kills them without waiting for a flop.
  assign mem_req    = ctrl_q.mem_req  & rst_n;
  assign memwrite   = ctrl_q.memwrite & rst_n;
  assign regwrite   = ctrl_q.regwrite & rst_n;
  assign irwrite    = (state == FETCH) & mem_ready & rst_n;
  assign pcen       = (((state == FETCH) & mem_ready) | ((state == BRANCH) & zero) |
                       ctrl_q.pcjump) & rst_n;
  assign illegal_op = (state == DECODE) & ~op_supported(opcode) & rst_n;
  assign iord       = ctrl_q.iord;
  assign regdst     = ctrl_q.regdst;
  assign memtoreg   = ctrl_q.memtoreg;
  assign alusrca    = ctrl_q.alusrca;
  assign alusrcb    = ctrl_q.alusrcb;
  assign ext_zero   = ctrl_q.ext_zero;
  assign pcsrc      = ctrl_q.pcsrc;
  assign alucontrol = ctrl_q.alucontrol;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-cycle expected control words
// from a state-table model are queued as stimulus is applied and compared at negedge.
module tb_mips_multicycle_ctrl;

  typedef enum int {
    T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
    T_EXECUTE, T_ALUWB, T_BRANCH, T_IMMEXEC, T_IMMWB, T_JUMP
  } ts_t;

  localparam int W = 18;
  // {mem_req,memwrite,iord,irwrite,pcen,regwrite,regdst,memtoreg,alusrca,alusrcb,ext_zero,pcsrc,alucontrol,illegal_op}
  localparam logic [W-1:0] RST_VEC = 18'b0_0_0_0_0_0_0_0_0_01_0_00_010_0;

  logic       clk, rst_n, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic       mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg;
  logic       alusrca, ext_zero, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite), .iord(iord),
    .irwrite(irwrite), .pcen(pcen), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .ext_zero(ext_zero),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal_op(illegal_op)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] observed();
    return {mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
            alusrca, alusrcb, ext_zero, pcsrc, alucontrol, illegal_op};
  endfunction

  // Reference control word for one cycle in state s.
  function automatic logic [W-1:0] ev(input ts_t s, input logic [5:0] op, input logic [5:0] fn,
                                      input logic mr, input logic z);
    logic mreq, mw, io, irw, pce, rw, rd, m2r, asa, ez, ill;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    {mreq, mw, io, irw, pce, rw, rd, m2r, asa, ez, ill} = '0;
    sb = 2'b00; ps = 2'b00; ac = 3'b000;
    case (s)
      T_FETCH:    begin mreq = 1; sb = 2'b01; ac = 3'b010; irw = mr; pce = mr; end
      T_DECODE: begin
        sb = 2'b11; ac = 3'b010;
        ill = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                           6'b001000, 6'b001100, 6'b001101, 6'b000010});
      end
      T_MEMADR:   begin asa = 1; sb = 2'b10; ac = 3'b010; end
      T_MEMREAD:  begin mreq = 1; io = 1; end
      T_MEMWB:    begin rw = 1; m2r = 1; end
      T_MEMWRITE: begin mreq = 1; io = 1; mw = 1; end
      T_EXECUTE: begin
        asa = 1; sb = 2'b00;
        case (fn)
          6'b100000: ac = 3'b010;
          6'b100010: ac = 3'b110;
          6'b100100: ac = 3'b000;
          6'b100101: ac = 3'b001;
          6'b101010: ac = 3'b111;
          default:   ac = 3'b010;
        endcase
      end
      T_ALUWB:    begin rw = 1; rd = 1; end
      T_BRANCH:   begin asa = 1; ac = 3'b110; ps = 2'b01; pce = z; end
      T_IMMEXEC, T_IMMWB: begin
        if (s == T_IMMEXEC) begin asa = 1; sb = 2'b10; end
        else rw = 1;
        case (op)
          6'b001100: begin ac = 3'b000; ez = 1; end
          6'b001101: begin ac = 3'b001; ez = 1; end
          default:   begin ac = 3'b010; ez = 0; end
        endcase
      end
      T_JUMP:     begin ps = 2'b10; pce = 1; end
      default:    ;
    endcase
    return {mreq, mw, io, irw, pce, rw, rd, m2r, asa, sb, ez, ps, ac, ill};
  endfunction

  // Driver: apply inputs for one cycle, queue the expectation, check at negedge.
  task automatic step(input string name, input ts_t s, input logic mr, input logic z);
    logic [W-1:0] e, got;
    mem_ready = mr;
    zero      = z;
    exp_q.push_back(ev(s, opcode, funct, mr, z));
    @(negedge clk);
    got = observed();
    e   = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b (op=%b fn=%b)", name, got, e, opcode, funct);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fetch_stall, input int mem_stall, input logic z);
    opcode = op;
    funct  = fn;
    repeat (fetch_stall) step("fetch_wait", T_FETCH, 1'b0, rnd());
    step("fetch", T_FETCH, 1'b1, rnd());
    step("decode", T_DECODE, rnd(), rnd());
    case (op)
      6'b100011: begin
        step("memadr", T_MEMADR, rnd(), rnd());
        repeat (mem_stall) step("memread_wait", T_MEMREAD, 1'b0, rnd());
        step("memread", T_MEMREAD, 1'b1, rnd());
        step("memwb", T_MEMWB, rnd(), rnd());
      end
      6'b101011: begin
        step("memadr", T_MEMADR, rnd(), rnd());
        repeat (mem_stall) step("memwrite_wait", T_MEMWRITE, 1'b0, rnd());
        step("memwrite", T_MEMWRITE, 1'b1, rnd());
      end
      6'b000000: begin
        step("execute", T_EXECUTE, rnd(), rnd());
        step("aluwb", T_ALUWB, rnd(), rnd());
      end
      6'b000100: step("branch", T_BRANCH, rnd(), z);
      6'b001000, 6'b001100, 6'b001101: begin
        step("immexec", T_IMMEXEC, rnd(), rnd());
        step("immwb", T_IMMWB, rnd(), rnd());
      end
      6'b000010: step("jump", T_JUMP, rnd(), rnd());
      default: ;
    endcase
  endtask

  task automatic check_now(input string name, input logic [W-1:0] e);
    logic [W-1:0] got;
    exp_q.push_back(e);
    got = observed();
    n_vec++;
    if (got !== exp_q.pop_front()) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b", name, got, e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; opcode = 6'b000000; funct = 6'b100000;
    repeat (2) begin
      @(negedge clk);
      check_now("reset_hold", RST_VEC);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_instr(6'b000000, 6'b100000, 0, 0, 1'b0);
  endtask

  task automatic test_lw_stall();
    run_instr(6'b100011, 6'b000000, 0, 2, 1'b0);
    run_instr(6'b100011, 6'b000000, 1, 0, 1'b0);
  endtask

  task automatic test_rtype();
    run_instr(6'b000000, 6'b101010, 0, 0, 1'b0);
    run_instr(6'b000000, 6'b100010, 0, 0, 1'b0);
    run_instr(6'b000000, 6'b111111, 0, 0, 1'b0);
  endtask

  task automatic test_imm();
    run_instr(6'b001101, 6'b000000, 0, 0, 1'b0);
    run_instr(6'b001000, 6'b000000, 0, 0, 1'b0);
    run_instr(6'b001100, 6'b000000, 0, 0, 1'b0);
  endtask

  task automatic test_beq_jump();
    run_instr(6'b000100, 6'b000000, 0, 0, 1'b1);
    run_instr(6'b000100, 6'b000000, 0, 0, 1'b0);
    run_instr(6'b000010, 6'b000000, 0, 0, 1'b0);
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 6'b000000, 0, 0, 1'b0);
    run_instr(6'b000011, 6'b000000, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_write();
    run_instr(6'b101011, 6'b000000, 0, 1, 1'b0);
    opcode = 6'b101011;
    step("fetch", T_FETCH, 1'b1, 1'b0);
    step("decode", T_DECODE, 1'b1, 1'b0);
    step("memadr", T_MEMADR, 1'b1, 1'b0);
    step("memwrite_wait", T_MEMWRITE, 1'b0, 1'b0);
    mem_ready = 1'b0;
    #1 check_now("memwrite_before_reset", ev(T_MEMWRITE, opcode, funct, 1'b0, 1'b0));
    rst_n = 1'b0;
    #1 check_now("memwrite_async_reset", RST_VEC);
    mem_ready = 1'b1;
    @(negedge clk);
    check_now("reset_after_write", RST_VEC);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_instr(6'b001101, 6'b000000, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[10];
    logic [5:0] fns[6];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
            6'b001100, 6'b001101, 6'b000010, 6'b111111, 6'b010000};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    for (int i = 0; i < 24; i++) begin
      run_instr(ops[$urandom_range(0, 9)], fns[$urandom_range(0, 5)],
                $urandom_range(0, 2), $urandom_range(0, 3), rnd());
    end
  endtask

  initial begin
    test_reset();
    test_lw_stall();
    test_rtype();
    test_imm();
    test_beq_jump();
    test_illegal();
    test_reset_mid_write();
    test_back_to_back();
    step("final_fetch", T_FETCH, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
